// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state encodings and defaults for the instruction sequencer
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_FETCH = 3'd1,
      SEQ_EXEC  = 3'd2,
      SEQ_MEM   = 3'd3,
      SEQ_STALL = 3'd4,
      SEQ_ERROR = 3'd5
   } seq_state_t;

   localparam int          SEQ_TIMEOUT_DEFAULT = 15;
   localparam logic [15:0] SEQ_NOP_INSTR       = 16'hF000;
   localparam int          SEQ_WAIT_W          = 8;

   function automatic logic seq_is_bus_state(input seq_state_t s);
      return (s == SEQ_FETCH) || (s == SEQ_MEM);
   endfunction

endpackage

// File: rtl/cpu_sequencer_seq_timeout_counter.sv
// rtl/cpu_sequencer_seq_timeout_counter.sv - per-request memory wait counter
module seq_timeout_counter
   import cpu_sequencer_pkg::*;
#(
   parameter int TIMEOUT = SEQ_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [SEQ_WAIT_W-1:0] LAST = SEQ_WAIT_W'(TIMEOUT - 1);

   logic [SEQ_WAIT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Flags the cycle whose missed ready would bring the count up to TIMEOUT.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute/memory sequencer driving the memory port and commit pulses
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int          TIMEOUT   = SEQ_TIMEOUT_DEFAULT,
   parameter logic [15:0] NOP_INSTR = SEQ_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   input  logic        dec_mem_read,
   input  logic        dec_mem_write,
   input  logic        dec_mem_word,
   input  logic        dec_commit_en,
   input  logic        cond_met,
   input  logic        stall_req,
   output logic [15:0] instr,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_word,
   output logic        mem_addr_sel,
   output logic        pc_inc,
   output logic        commit,
   output logic        bus_error,
   output logic [2:0]  state
);

   seq_state_t  state_q;
   seq_state_t  state_d;
   seq_state_t  after_instr;
   logic [15:0] instr_q;
   logic        is_read;
   logic        is_write;
   logic        fetch_done;
   logic        wait_clear;
   logic        wait_enable;
   logic        wait_expired;

   // A simultaneous read and write request resolves to a read.
   assign is_read     = dec_mem_read;
   assign is_write    = dec_mem_write & ~dec_mem_read;
   assign after_instr = stall_req ? SEQ_STALL : SEQ_FETCH;
   assign fetch_done  = (state_q == SEQ_FETCH) && mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEQ_IDLE;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         if (fetch_done) begin
            instr_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_word     = 1'b0;
      mem_addr_sel = 1'b0;
      pc_inc       = 1'b0;
      commit       = 1'b0;
      bus_error    = 1'b0;
      case (state_q)
         SEQ_IDLE: state_d = after_instr;
         SEQ_FETCH: begin
            mem_req  = 1'b1;
            mem_word = 1'b1;
            if (mem_ready) begin
               pc_inc  = 1'b1;
               state_d = SEQ_EXEC;
            end else if (wait_expired) begin
               state_d = SEQ_ERROR;
            end
         end
         SEQ_EXEC: begin
            if (is_read || is_write) begin
               state_d = SEQ_MEM;
            end else begin
               commit  = dec_commit_en & cond_met;
               state_d = after_instr;
            end
         end
         SEQ_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_write;
            mem_word     = dec_mem_word;
            if (mem_ready) begin
               commit  = is_read & dec_commit_en & cond_met;
               state_d = after_instr;
            end else if (wait_expired) begin
               state_d = SEQ_ERROR;
            end
         end
         SEQ_STALL: state_d = after_instr;
         SEQ_ERROR: bus_error = 1'b1;
         default:   state_d = SEQ_IDLE;
      endcase
      // Reset silences the port in the same cycle so an in-flight ready cannot commit.
      if (reset) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_word     = 1'b0;
         mem_addr_sel = 1'b0;
         pc_inc       = 1'b0;
         commit       = 1'b0;
         bus_error    = 1'b0;
      end
   end

   assign wait_clear  = (state_d != state_q);
   assign wait_enable = seq_is_bus_state(state_q) && !mem_ready;

   seq_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clear   (wait_clear),
      .enable  (wait_enable),
      .expired (wait_expired)
   );

   assign instr = instr_q;
   assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - table, directed and randomized checks for cpu_sequencer
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam int TO = 15;
   localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_MEM = 3, P_STALL = 4, P_ERR = 5;

   logic        clk = 1'b0;
   logic        reset, mem_ready, dec_mem_read, dec_mem_write, dec_mem_word;
   logic        dec_commit_en, cond_met, stall_req;
   logic [15:0] mem_rdata, instr;
   logic        mem_req, mem_we, mem_word, mem_addr_sel, pc_inc, commit, bus_error;
   logic [2:0]  state;

   cpu_sequencer #(.TIMEOUT(TO), .NOP_INSTR(16'hF000)) dut (
      .clk(clk), .reset(reset), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_mem_word(dec_mem_word),
      .dec_commit_en(dec_commit_en), .cond_met(cond_met), .stall_req(stall_req),
      .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .mem_word(mem_word),
      .mem_addr_sel(mem_addr_sel), .pc_inc(pc_inc), .commit(commit),
      .bus_error(bus_error), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [6:0]  in_bits;   // {rdy, rd, wr, dw, ce, cm, stall}
      logic [15:0] rdata;
      logic [2:0]  exp_state;
      logic [5:0]  exp_ctl;   // {req, we, word, sel, pc_inc, commit}
      logic [15:0] exp_instr;
   } vec_t;
   vec_t vecs[$];

   int          m_phase, m_wait, m_errcyc, n_phase;
   logic [15:0] m_instr, n_instr;
   logic [6:0]  e_out;        // {req, we, word, sel, pc_inc, commit, bus_error}

   task automatic drive(input logic rs, input logic [6:0] b, input logic [15:0] d);
      reset = rs;
      {mem_ready, dec_mem_read, dec_mem_write, dec_mem_word, dec_commit_en, cond_met, stall_req} = b;
      mem_rdata = d;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [5:0] ctl_now();
      return {mem_req, mem_we, mem_word, mem_addr_sel, pc_inc, commit};
   endfunction

   task automatic do_reset;
      drive(1'b1, 7'b0, 16'h0);
      #2;
      chk("reset_outputs", {26'b0, ctl_now()}, 32'h0);
      tick;
   endtask

   task automatic add(input logic [6:0] b, input logic [15:0] d, input seq_state_t s,
                      input logic [5:0] c, input logic [15:0] i);
      vec_t v;
      v.in_bits = b; v.rdata = d; v.exp_state = s; v.exp_ctl = c; v.exp_instr = i;
      vecs.push_back(v);
   endtask

   function automatic logic [2:0] enc(input int p);
      case (p)
         P_IDLE:  return SEQ_IDLE;
         P_FETCH: return SEQ_FETCH;
         P_EXEC:  return SEQ_EXEC;
         P_MEM:   return SEQ_MEM;
         P_STALL: return SEQ_STALL;
         default: return SEQ_ERROR;
      endcase
   endfunction

   task automatic model_eval(input logic rs, input logic [6:0] b, input logic [15:0] d);
      logic rdy, rd, wr, dw, ce, cm, st;
      int   after;
      {rdy, rd, wr, dw, ce, cm, st} = b;
      after   = st ? P_STALL : P_FETCH;
      e_out   = '0;
      n_phase = m_phase;
      n_instr = m_instr;
      case (m_phase)
         P_IDLE: n_phase = after;
         P_FETCH: begin
            e_out[6] = 1'b1; e_out[4] = 1'b1;
            if (rdy) begin e_out[2] = 1'b1; n_instr = d; n_phase = P_EXEC; end
            else if (m_wait + 1 == TO) n_phase = P_ERR;
         end
         P_EXEC: begin
            if (rd || wr) n_phase = P_MEM;
            else begin e_out[1] = ce && cm; n_phase = after; end
         end
         P_MEM: begin
            e_out[6] = 1'b1; e_out[3] = 1'b1; e_out[5] = wr && !rd; e_out[4] = dw;
            if (rdy) begin e_out[1] = rd && ce && cm; n_phase = after; end
            else if (m_wait + 1 == TO) n_phase = P_ERR;
         end
         P_STALL: n_phase = after;
         default: e_out[0] = 1'b1;
      endcase
      if (rs) begin e_out = '0; n_phase = P_IDLE; n_instr = 16'hF000; end
   endtask

   task automatic model_commit(input logic rs, input logic rdy);
      if (rs || n_phase != m_phase) m_wait = 0;
      else if ((m_phase == P_FETCH || m_phase == P_MEM) && !rdy) m_wait++;
      m_errcyc = (m_phase == P_ERR && n_phase == P_ERR) ? m_errcyc + 1 : 0;
      m_phase  = n_phase;
      m_instr  = n_instr;
   endtask

   initial begin
      logic        rs, rdy;
      logic [6:0]  b;
      logic [15:0] d;
      int          starve;

      do_reset;

      // Instruction stream: math, load with waits, store, read+write, stall window.
      add(7'b1000110, 16'h0000, SEQ_IDLE,  6'b000000, 16'hF000);
      add(7'b1000110, 16'h0123, SEQ_FETCH, 6'b101010, 16'hF000);
      add(7'b1000110, 16'h0000, SEQ_EXEC,  6'b000001, 16'h0123);
      add(7'b1000110, 16'h0124, SEQ_FETCH, 6'b101010, 16'h0123);
      add(7'b1000100, 16'h0000, SEQ_EXEC,  6'b000000, 16'h0124);
      add(7'b0000000, 16'h0777, SEQ_FETCH, 6'b101000, 16'h0124);
      add(7'b1000000, 16'h0200, SEQ_FETCH, 6'b101010, 16'h0124);
      add(7'b0100110, 16'h0000, SEQ_EXEC,  6'b000000, 16'h0200);
      add(7'b0100110, 16'hBEEF, SEQ_MEM,   6'b100100, 16'h0200);
      add(7'b0100110, 16'hBEEF, SEQ_MEM,   6'b100100, 16'h0200);
      add(7'b0100110, 16'hBEEF, SEQ_MEM,   6'b100100, 16'h0200);
      add(7'b1100110, 16'hBEEF, SEQ_MEM,   6'b100101, 16'h0200);
      add(7'b1000000, 16'h0300, SEQ_FETCH, 6'b101010, 16'h0200);
      add(7'b0011110, 16'h0000, SEQ_EXEC,  6'b000000, 16'h0300);
      add(7'b1011110, 16'h5555, SEQ_MEM,   6'b111100, 16'h0300);
      add(7'b1000000, 16'h0400, SEQ_FETCH, 6'b101010, 16'h0300);
      add(7'b0111110, 16'h0000, SEQ_EXEC,  6'b000000, 16'h0400);
      add(7'b1111110, 16'h6666, SEQ_MEM,   6'b101101, 16'h0400);
      add(7'b1000000, 16'h0500, SEQ_FETCH, 6'b101010, 16'h0400);
      add(7'b0000111, 16'h0000, SEQ_EXEC,  6'b000001, 16'h0500);
      for (int k = 0; k < 4; k++) add(7'b0000001, 16'h0000, SEQ_STALL, 6'b000000, 16'h0500);
      add(7'b1000000, 16'hDEAD, SEQ_STALL, 6'b000000, 16'h0500);
      add(7'b1000000, 16'h0600, SEQ_FETCH, 6'b101010, 16'h0500);
      add(7'b0000000, 16'h0000, SEQ_EXEC,  6'b000000, 16'h0600);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b0, vecs[i].in_bits, vecs[i].rdata);
         #2;
         chk($sformatf("vec%0d_state", i), {29'b0, state}, {29'b0, vecs[i].exp_state});
         chk($sformatf("vec%0d_ctl", i), {26'b0, ctl_now()}, {26'b0, vecs[i].exp_ctl});
         chk($sformatf("vec%0d_instr", i), {16'b0, instr}, {16'b0, vecs[i].exp_instr});
         tick;
      end

      // Fetch never answered: exactly TO cycles of FETCH, then sticky ERROR.
      do_reset;
      drive(1'b0, 7'b0, 16'h0); #2;
      chk("to_idle", {29'b0, state}, {29'b0, 3'(SEQ_IDLE)});
      tick;
      for (int k = 0; k < TO; k++) begin
         drive(1'b0, 7'b0, 16'h0); #2;
         chk($sformatf("to_fetch%0d", k), {28'b0, state, mem_req}, {28'b0, 3'(SEQ_FETCH), 1'b1});
         tick;
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 7'b1000000, 16'h1111); #2;
         chk($sformatf("to_error%0d", k), {26'b0, state, bus_error, mem_req, pc_inc},
             {26'b0, 3'(SEQ_ERROR), 1'b1, 1'b0, 1'b0});
         tick;
      end

      // Ready arriving on the last permitted cycle completes normally.
      do_reset;
      drive(1'b0, 7'b0, 16'h0); tick;
      for (int k = 0; k < TO - 1; k++) begin drive(1'b0, 7'b0, 16'h0); tick; end
      drive(1'b0, 7'b1000000, 16'h2222); #2;
      chk("edge_pc_inc", {31'b0, pc_inc}, 32'd1);
      tick;
      drive(1'b0, 7'b0, 16'h0); #2;
      chk("edge_exec", {28'b0, state, bus_error}, {28'b0, 3'(SEQ_EXEC), 1'b0});
      chk("edge_instr", {16'b0, instr}, 32'h2222);
      tick;

      // Reset landing on a MEM cycle with ready must not commit.
      do_reset;
      drive(1'b0, 7'b0, 16'h0); tick;
      drive(1'b0, 7'b1000000, 16'h1234); tick;
      drive(1'b0, 7'b0100110, 16'h0); tick;
      drive(1'b0, 7'b0100110, 16'h0); #2;
      chk("rst_mem_state", {29'b0, state}, {29'b0, 3'(SEQ_MEM)});
      tick;
      drive(1'b1, 7'b1100110, 16'h9999); #2;
      chk("rst_mem_commit", {31'b0, commit}, 32'd0);
      tick;
      drive(1'b0, 7'b0, 16'h0); #2;
      chk("rst_mem_after", {12'b0, state, mem_req, instr}, {12'b0, 3'(SEQ_IDLE), 1'b0, 16'hF000});
      tick;

      // Randomized run against the reference model.
      do_reset;
      m_phase = P_IDLE; m_wait = 0; m_errcyc = 0; m_instr = 16'hF000;
      starve = 0;
      for (int c = 0; c < 4000; c++) begin
         rs = (m_phase == P_ERR && m_errcyc >= 3) || ($urandom_range(0, 299) == 0);
         if (starve > 0) begin
            rdy = 1'b0;
            starve--;
         end else begin
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 79) == 0) starve = $urandom_range(10, 20);
         end
         b = {rdy, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0)};
         d = 16'($urandom);
         drive(rs, b, d);
         #2;
         model_eval(rs, b, d);
         chk("rand", {6'b0, state, mem_req, mem_we, mem_word, mem_addr_sel, pc_inc, commit, bus_error, instr},
             {6'b0, enc(m_phase), e_out, m_instr});
         tick;
         model_commit(rs, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready per memory request (range 1..255).
REQ-002 Parameter NOP_INSTR, default 16'hF000: instruction register value after reset.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 mem_ready  in  1  memory completes the current request this cycle.
REQ-006 mem_rdata  in  16  memory read data, valid when mem_ready=1.
REQ-007 dec_mem_read  in  1  decoded instruction reads memory (byte or word).
REQ-008 dec_mem_write  in  1  decoded instruction writes memory (byte or word).
REQ-009 dec_mem_word  in  1  decoded memory access is word (1) or byte (0).
REQ-010 dec_commit_en  in  1  decoded instruction may write its destination (set-condition enable bit).
REQ-011 cond_met  in  1  Z/C flag condition of the decoded instruction is satisfied.
REQ-012 stall_req  in  1  external request to hold before the next fetch.
REQ-013 instr  out  16  latched current instruction, feeds the decoder.
REQ-014 mem_req  out  1  memory request active.
REQ-015 mem_we  out  1  request is a write.
REQ-016 mem_word  out  1  request is word sized.
REQ-017 mem_addr_sel  out  1  address source: 0 = PC (fetch), 1 = decoded register address (data).
REQ-018 pc_inc  out  1  one-cycle pulse: advance PC by 2.
REQ-019 commit  out  1  one-cycle pulse: write ALU result to register/PC destination.
REQ-020 bus_error  out  1  sticky timeout flag.
REQ-021 state  out  3  current FSM state encoding, for debug.

Function
REQ-022 States SHALL be IDLE, FETCH, EXEC, MEM, STALL, ERROR; IDLE -> FETCH unconditionally after one cycle.
REQ-023 FETCH SHALL drive mem_req=1, mem_addr_sel=0, mem_word=1, mem_we=0; on mem_ready it SHALL latch instr<=mem_rdata, pulse pc_inc, and go to EXEC.
REQ-024 EXEC SHALL last exactly one cycle; if dec_mem_read or dec_mem_write, go to MEM, else pulse commit=dec_commit_en&cond_met and go to FETCH (or STALL).
REQ-025 MEM SHALL drive mem_req=1, mem_addr_sel=1, mem_we=dec_mem_write, mem_word=dec_mem_word; on mem_ready go to FETCH (or STALL).
REQ-026 In MEM, commit SHALL pulse in the mem_ready cycle only for reads with dec_commit_en&cond_met; writes never commit.
REQ-027 dec_mem_read and dec_mem_write both 1 SHALL be treated as a read.
REQ-028 Every transition into FETCH SHALL go to STALL instead if stall_req=1 in that cycle; STALL SHALL hold all requests low and exit to FETCH in the first cycle stall_req=0.
REQ-029 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready=0 in those states; reaching TIMEOUT without mem_ready SHALL go to ERROR.
REQ-030 mem_ready in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-031 ERROR SHALL set bus_error=1, drive mem_req=0, and remain until reset.
REQ-032 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-033 Minimum latency: 2 cycles per non-memory instruction, 3 cycles per memory instruction.
REQ-034 pc_inc and commit SHALL never be high for more than one consecutive cycle per instruction.

Reset
REQ-035 On reset: state=IDLE, instr=NOP_INSTR, wait counter=0, bus_error=0, and mem_req, mem_we, mem_word, mem_addr_sel, pc_inc, commit = 0.
REQ-036 Reset during FETCH/MEM SHALL drop mem_req in the next cycle and discard any in-flight mem_ready.

Structure
REQ-037 State encodings, TIMEOUT default and NOP_INSTR default SHALL live in the shared CPU package.
REQ-038 The wait counter SHALL be a sub-module seq_timeout_counter (clear, enable, expired output).

Verification
REQ-039 Reset, mem_ready=1 always, mem_rdata=16'h0123 (math instr), dec_commit_en=1, cond_met=1 -> pc_inc at cycle 2, commit at cycle 3, repeating every 2 cycles.
REQ-040 Load (dec_mem_read=1, dec_mem_word=0), mem_ready delayed 3 cycles in MEM -> mem_addr_sel=1, mem_word=0 held 4 cycles, commit in the ready cycle.
REQ-041 Store (dec_mem_write=1, dec_mem_word=1) -> mem_we=1, mem_word=1 for one MEM cycle, commit stays 0.
REQ-042 mem_ready held 0 in FETCH with TIMEOUT=15 -> ERROR after 15 cycles, bus_error=1, mem_req=0 until reset.
REQ-043 stall_req=1 during EXEC for 5 cycles -> STALL for 5 cycles, no mem_req, FETCH resumes on the first cycle stall_req=0.
REQ-044 Reset asserted mid-MEM with mem_ready=1 -> no commit, state=IDLE, instr=16'hF000.
